// File: rtl/imem_dmem_arbiter_if.sv
// Shared memory-port bundle between fetch, load/store unit, and the memory wrapper.
// slave = arbiter side, master = pipeline/memory environment side.
interface imem_dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            i_flush;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            ls_req;
  logic            ls_we;
  logic [DW/8-1:0] ls_be;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [DW-1:0]   ls_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  i_flush,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output i_flush,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Fetch / load-store arbiter for one memory port, LS priority with fetch starvation guard.
// Optional ARB_BACK2BACK_EN: re-arbitrate during the response cycle for one transaction per cycle.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no transaction outstanding, arbitrating pending requests
// WAIT_RSP | one transaction issued, waiting for mem_rvalid
module imem_dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  imem_dmem_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;     // 1 = LS
  logic          drop_q, drop_d;
  logic [CW-1:0] starve_q, starve_d;

  logic starved, sel_ls, sel_if, arb_en, grant, rsp;

  always_comb begin
    starved = bus.if_req && (starve_q == CW'(STARVE_LIMIT));
    sel_ls  = bus.ls_req && !starved;
    sel_if  = bus.if_req && !sel_ls;
`ifdef ARB_BACK2BACK_EN
    arb_en  = (state_q == IDLE) || bus.mem_rvalid;
`else
    arb_en  = (state_q == IDLE);
`endif
  end

  // Outputs are forced low while reset is held since the reset is synchronous.
  always_comb begin
    bus.mem_req   = rst_n && arb_en && (bus.ls_req || bus.if_req);
    bus.mem_we    = 1'b0;
    bus.mem_be    = '1;
    bus.mem_addr  = bus.if_addr;
    bus.mem_wdata = '0;
    if (sel_ls) begin
      bus.mem_we    = bus.ls_we;
      bus.mem_be    = bus.ls_be;
      bus.mem_addr  = bus.ls_addr;
      bus.mem_wdata = bus.ls_wdata;
    end
    grant         = bus.mem_req && bus.mem_gnt;
    bus.ls_gnt    = grant && sel_ls;
    bus.if_gnt    = grant && sel_if;
    rsp           = rst_n && (state_q == WAIT_RSP) && bus.mem_rvalid;
    bus.if_rvalid = rsp && !owner_q && !drop_q && !bus.i_flush;
    bus.ls_rvalid = rsp && owner_q;
    bus.if_rdata  = bus.mem_rdata;
    bus.ls_rdata  = bus.mem_rdata;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = WAIT_RSP;
          owner_d = sel_ls;
          drop_d  = 1'b0;
        end
      end
      WAIT_RSP: begin
        if (bus.i_flush && !owner_q) drop_d = 1'b1;
        if (bus.mem_rvalid) begin
          if (grant) begin
            owner_d = sel_ls;
            drop_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || bus.if_gnt)
      starve_d = '0;
    else if (bus.ls_gnt && (starve_q != CW'(STARVE_LIMIT)))
      starve_d = starve_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      drop_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: grants push expected responses, rvalids pop and compare.
module tb_imem_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
`ifdef ARB_BACK2BACK_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  typedef struct packed {
    logic        is_ls;
    logic        we;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic        mem_auto;
  logic        pend;
  logic [31:0] pend_addr;
  logic        g_if, g_ls, rv_if, rv_ls;

  imem_dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  imem_dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
  endfunction

  // Observe one cycle at the negedge, then advance to just after the next posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    g_if  = bus.if_gnt;
    g_ls  = bus.ls_gnt;
    rv_if = bus.if_rvalid;
    rv_ls = bus.ls_rvalid;
    if (rv_if || rv_ls) begin
      checks++;
      if (rv_if && rv_ls) begin
        errors++;
        $display("FAIL both_rvalid: if_rvalid=%0b ls_rvalid=%0b, required one-hot", rv_if, rv_ls);
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: if_rvalid=%0b ls_rvalid=%0b, required none", rv_if, rv_ls);
      end else begin
        e = q.pop_front();
        if (e.is_ls !== rv_ls) begin
          errors++;
          $display("FAIL rsp_side: got ls=%0b, required ls=%0b", rv_ls, e.is_ls);
        end else if (!e.we && ((rv_ls ? bus.ls_rdata : bus.if_rdata) !== e.data)) begin
          errors++;
          $display("FAIL rsp_data: got %h, required %h", rv_ls ? bus.ls_rdata : bus.if_rdata, e.data);
        end
      end
    end
    pend      = bus.mem_req && bus.mem_gnt;
    pend_addr = bus.mem_addr;
    if (pend) q.push_back({bus.ls_gnt, bus.mem_we, mem_fn(bus.mem_addr)});
    @(posedge clk);
    #1;
    if (mem_auto) begin
      bus.mem_rvalid = pend;
      bus.mem_rdata  = pend ? mem_fn(pend_addr) : $urandom;
    end
  endtask

  task automatic drain();
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    bus.mem_rvalid = 1'b1;
    #1;
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.if_rvalid, bus.ls_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: gnt/req/rvalid=%b, required 00000",
               {bus.if_gnt, bus.ls_gnt, bus.mem_req, bus.if_rvalid, bus.ls_rvalid});
    end
    bus.mem_rvalid = 1'b0;
    bus.ls_req     = 1'b0;
    bus.if_req     = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_read();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    tick();
    checks++;
    if (g_if !== 1'b1 || g_ls !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt: if_gnt=%0b ls_gnt=%0b, required 1/0", g_if, g_ls);
    end
    bus.if_req = 1'b0;
    tick();
    checks++;
    if (rv_if !== 1'b1) begin
      errors++;
      $display("FAIL fetch_rvalid: if_rvalid=%0b, required 1", rv_if);
    end
    drain();
  endtask

  task automatic test_ls_priority();
    bit ack_seen = 0;
    bit if_seen  = 0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h80;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 32'h100;
    bus.ls_wdata = 32'hDEADBEEF;
    bus.ls_be    = 4'hF;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEADBEEF ||
        bus.mem_be !== 4'hF) begin
      errors++;
      $display("FAIL ls_fields: we=%0b addr=%h wdata=%h be=%h, required 1/00000100/deadbeef/f",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    checks++;
    if (bus.ls_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL ls_first: ls_gnt=%0b if_gnt=%0b, required 1/0", bus.ls_gnt, bus.if_gnt);
    end
    tick();
    bus.ls_req = 1'b0;
    bus.ls_we  = 1'b0;
    for (int c = 0; c < 8 && !if_seen; c++) begin
      tick();
      if (rv_ls) ack_seen = 1;
      if (g_if) begin
        if_seen    = 1;
        bus.if_req = 1'b0;
      end
    end
    checks++;
    if (!ack_seen || !if_seen) begin
      errors++;
      $display("FAIL ls_then_if: ls_ack=%0b if_gnt=%0b, required 1/1", ack_seen, if_seen);
    end
    drain();
  endtask

  task automatic test_starvation();
    int k = 0;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_be   = 4'hF;
    bus.ls_addr = 32'h200;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    for (int c = 0; c < 80 && k < 15; c++) begin
      tick();
      if (g_if || g_ls) begin
        checks++;
        if (g_ls !== ((k % 5) != 4)) begin
          errors++;
          $display("FAIL starve_order: grant %0d ls_gnt=%0b, required %0b", k, g_ls, (k % 5) != 4);
        end
        k++;
      end
    end
    checks++;
    if (k < 15) begin
      errors++;
      $display("FAIL starve_timeout: %0d grants, required 15", k);
    end
    drain();
  endtask

  task automatic test_flush();
    mem_auto       = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h300;
    tick();
    void'(q.pop_back());
    bus.if_req  = 1'b0;
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    #1;
    checks++;
    if (bus.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: if_rvalid=%0b, required 0", bus.if_rvalid);
    end
    tick();
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h304;
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: if_gnt=%0b, required 1", bus.if_gnt);
    end
    tick();
    void'(q.pop_back());
    bus.if_req = 1'b0;
    tick();
    bus.i_flush    = 1'b1;
    bus.mem_rvalid = 1'b1;
    #1;
    checks++;
    if (bus.if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL flush_coincident: if_rvalid=%0b, required 0", bus.if_rvalid);
    end
    tick();
    bus.i_flush    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h308;
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle2: if_gnt=%0b, required 1", bus.if_gnt);
    end
    tick();
    bus.if_req     = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = mem_fn(32'h308);
    tick();
    checks++;
    if (rv_if !== 1'b1) begin
      errors++;
      $display("FAIL post_flush_rsp: if_rvalid=%0b, required 1", rv_if);
    end
    bus.mem_rvalid = 1'b0;
    mem_auto       = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    mem_auto       = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h500;
    tick();
    void'(q.pop_back());
    bus.if_req = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    #1;
    checks++;
    if (bus.if_rvalid !== 1'b0 || bus.ls_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid: if_rvalid=%0b ls_rvalid=%0b, required 0/0", bus.if_rvalid, bus.ls_rvalid);
    end
    tick();
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b1;
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: if_gnt=%0b, required 1", bus.if_gnt);
    end
    tick();
    bus.if_req     = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = mem_fn(32'h500);
    tick();
    bus.mem_rvalid = 1'b0;
    mem_auto       = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int n    = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h400;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (g_if) begin
        if (last >= 0) begin
          checks++;
          if (c - last != GAP) begin
            errors++;
            $display("FAIL gnt_spacing: %0d cycles, required %0d", c - last, GAP);
          end
        end
        last = c;
        n++;
      end
    end
    checks++;
    if (n < 16 / GAP - 1) begin
      errors++;
      $display("FAIL gnt_count: %0d grants, required >= %0d", n, 16 / GAP - 1);
    end
    drain();
  endtask

  initial begin
    rst_n          = 1'b0;
    mem_auto       = 1'b1;
    pend           = 1'b0;
    pend_addr      = '0;
    bus.i_flush    = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.ls_req     = 1'b0;
    bus.ls_we      = 1'b0;
    bus.ls_be      = 4'hF;
    bus.ls_addr    = '0;
    bus.ls_wdata   = '0;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    test_reset();
    test_fetch_read();
    test_ls_priority();
    test_starvation();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Two-requester arbiter that shares the single synchronous memory port between the Fetch stage (instruction reads) and the load/store unit (data reads/writes). It sits between the core pipeline and the memory wrapper and uses a req/gnt/rvalid protocol with at most one outstanding transaction. Arbitration is fixed-priority to the load/store unit, with a starvation guard for fetch. Fetch responses are discarded when a pipeline flush occurs while the fetch access is in flight.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_LIMIT`, 4, consecutive LS grants while fetch waits before fetch is forced to win (≥1)

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `i_flush`  in  1  pipeline flush; drops an in-flight fetch response
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`
- `if_addr`  in  AW  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  DW  fetch read data
- `ls_req`  in  1  load/store request; held with its fields until `ls_gnt`
- `ls_we`  in  1  1 = write
- `ls_be`  in  DW/8  byte enables
- `ls_addr`  in  AW  data address
- `ls_wdata`  in  DW  write data
- `ls_gnt`  out  1  LS request accepted this cycle
- `ls_rvalid`  out  1  LS response valid (read data, or write ack)
- `ls_rdata`  out  DW  LS read data
- `mem_req`  out  1  memory request
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/DW/8/AW/DW  request fields
- `mem_gnt`  in  1  memory accepted request
- `mem_rvalid`  in  1  memory response valid
- `mem_rdata`  in  DW  memory read data

## Operation
- FSM states: `IDLE`, `WAIT_RSP`. Registered state: `owner` (0=IF, 1=LS), `drop` flag, `starve_cnt` (clog2(STARVE_LIMIT+1) bits, saturating).
- IDLE: select = LS if `ls_req` and not (`if_req` and `starve_cnt==STARVE_LIMIT`); else IF if `if_req`. `mem_req` = any request; request fields are muxed combinationally from the selected requester. IF requests drive `mem_we=0` and `mem_be` all ones.
- Selected `*_gnt` = `mem_gnt` & `mem_req`. On a grant: `owner` <= selected, `drop` <= 0, go to WAIT_RSP.
- WAIT_RSP: `mem_req=0` (base build). On `mem_rvalid`: pulse `if_rvalid` (owner IF and not `drop` and not `i_flush`) or `ls_rvalid` (owner LS), go to IDLE.
- `i_flush` while in WAIT_RSP with owner IF sets `drop`. `i_flush` does not affect LS transactions or IDLE arbitration.
- `mem_rvalid` in IDLE is ignored.
- `starve_cnt`: increments (saturating) on each LS grant while `if_req=1`; clears on IF grant or whenever `if_req=0`.
- `if_rdata` and `ls_rdata` are both wired directly to `mem_rdata`. They are qualified only by their rvalid.

## Timing
- Reset: state IDLE, `owner`=0, `drop`=0, `starve_cnt`=0.
- All grant and rvalid outputs and `mem_req` are 0 during reset.
- Grant latency: 0 cycles from `mem_gnt`. Response latency: 0 cycles from `mem_rvalid`. Both are combinational.
- Base build: one bubble cycle between a response and the next `mem_req`. Peak throughput is one transaction per 2 cycles with a memory that responds in 1 cycle.
- Both requesters active in the same cycle: LS wins unless starvation saturates. When it saturates, IF wins once and the counter clears.
- `i_flush` in the same cycle as `mem_rvalid` for an IF owner: `if_rvalid` stays 0.
- Reset mid-transaction: return to IDLE. A late `mem_rvalid` after reset is ignored.

## Configuration
- `ARB_BACK2BACK_EN` defined: in WAIT_RSP, during the `mem_rvalid` cycle, arbitration runs as in IDLE and `mem_req` may assert. A grant in that cycle stays in WAIT_RSP with the new `owner`, and `drop` is cleared. This gives one transaction per cycle.
- Not defined: `mem_req=0` throughout WAIT_RSP.

## Test plan
- Reset, then `if_req=1`, `if_addr=0x0000_0000`, `mem_gnt=1`, response after 1 cycle with `0x0000_0013` -> `if_gnt` in cycle 1, `if_rvalid=1` with `if_rdata=0x13` in cycle 2, and `ls_rvalid` never asserts.
- `if_req` and `ls_req` (write, `ls_addr=0x100`, `ls_wdata=0xDEADBEEF`, `ls_be=0xF`) both asserted -> `mem_we=1`, `mem_addr=0x100`, `ls_gnt` before `if_gnt`, then `ls_rvalid` ack.
- `ls_req` held continuously with `if_req=1` and `STARVE_LIMIT=4` -> exactly 4 LS grants, then 1 IF grant, repeating.
- IF request granted, `i_flush` pulsed while waiting, then `mem_rvalid` -> no `if_rvalid`, FSM returns to IDLE. Repeat with `i_flush` coincident with `mem_rvalid` -> same result.
- `rst_n=0` asserted in WAIT_RSP, then `mem_rvalid=1` after reset release -> no rvalid to either side, state IDLE.
- With `ARB_BACK2BACK_EN`, 1-cycle memory, `if_req` held -> `if_gnt` every cycle. Without it -> `if_gnt` every other cycle.
